// File: rtl/fpga_config_loader.sv
// Word-to-multichain serial configuration loader. Each accepted word is spread over CHAINS shift
// chains, S = WORD_W/CHAINS bits per chain, LSB first. Define CFG_CRC_EN to add a trailing CRC-16 check.
module fpga_config_loader #(
  parameter int CHAINS    = 4,
  parameter int WORD_W    = 16,
  parameter int CHAIN_LEN = 256
) (
  input  logic              shift_clk,
  input  logic              shift_rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              shift_en,
  output logic [CHAINS-1:0] shift_o,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_state
);

  localparam int S     = WORD_W / CHAINS;
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int SH_W  = (S > 1) ? $clog2(S) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN);
  localparam logic [SH_W-1:0]  LAST_SHFT = SH_W'(S - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
`ifdef CFG_CRC_EN
    CHECK = 3'd5,
`endif
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SH_W-1:0]    sh_q, sh_d;
  logic               shift_en_q, shift_en_d;
  logic [CHAINS-1:0]  shift_o_q, shift_o_d;
  logic               done_q, done_d;

`ifdef CFG_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic        error_q, error_d;

  // CRC-16-CCITT, MSB-first register, fed with the word's bits LSB first.
  function automatic logic [15:0] crc_fold(input logic [15:0] crc, input logic [WORD_W-1:0] w);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < WORD_W; i++) begin
      fb = c[15] ^ w[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  function automatic logic [15:0] crc_field(input logic [WORD_W-1:0] w);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) if (i < WORD_W) v[i] = w[i];
    return v;
  endfunction
`endif

  // Valid/ready: a word moves only on a cycle where cfg_valid and cfg_ready are both high;
  // cfg_ready depends on the registered state alone, so the producer may hold valid indefinitely.
`ifdef CFG_CRC_EN
  assign cfg_ready = (state_q == LOAD) || (state_q == CHECK);
  assign busy      = (state_q == LOAD) || (state_q == SHIFT) || (state_q == CHECK);
  assign error     = error_q;
`else
  assign cfg_ready = (state_q == LOAD);
  assign busy      = (state_q == LOAD) || (state_q == SHIFT);
  assign error     = 1'b0;
`endif
  assign shift_en  = shift_en_q;
  assign shift_o   = shift_o_q;
  assign done      = done_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    shift_en_d = 1'b0;
    shift_o_d  = '0;
    done_d     = done_q;
`ifdef CFG_CRC_EN
    crc_d      = crc_q;
    error_d    = error_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = LOAD;
          buf_d   = '0;
          cnt_d   = '0;
          sh_d    = '0;
          done_d  = 1'b0;
`ifdef CFG_CRC_EN
          crc_d   = 16'hFFFF;
          error_d = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (cfg_valid) begin
          buf_d   = cfg_data;
          sh_d    = '0;
          state_d = SHIFT;
`ifdef CFG_CRC_EN
          crc_d   = crc_fold(crc_q, cfg_data);
`endif
        end
      end
      SHIFT: begin
        shift_en_d = 1'b1;
        shift_o_d  = buf_q[CHAINS-1:0];
        buf_d      = buf_q >> CHAINS;
        cnt_d      = cnt_q + CNT_W'(1);
        if (sh_q == LAST_SHFT) begin
          sh_d = '0;
          if (cnt_d == LAST_BIT) begin
`ifdef CFG_CRC_EN
            state_d = CHECK;
`else
            state_d = DONE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = LOAD;
          end
        end else begin
          sh_d = sh_q + SH_W'(1);
        end
      end
`ifdef CFG_CRC_EN
      CHECK: begin
        if (cfg_valid) begin
          if (crc_field(cfg_data) == crc_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERROR;
            error_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge shift_clk or negedge shift_rst_n) begin
    if (!shift_rst_n) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      cnt_q      <= '0;
      sh_q       <= '0;
      shift_en_q <= 1'b0;
      shift_o_q  <= '0;
      done_q     <= 1'b0;
`ifdef CFG_CRC_EN
      crc_q      <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      shift_en_q <= shift_en_d;
      shift_o_q  <= shift_o_d;
      done_q     <= done_d;
`ifdef CFG_CRC_EN
      crc_q      <= crc_d;
      error_q    <= error_d;
`endif
    end
  end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Directed bench for fpga_config_loader: a CHAIN_LEN=8 instance for bit mapping, stalls, busy-start
// and reset, and a default-size instance for a full random load. Follows CFG_CRC_EN when defined.
module tb_fpga_config_loader;

  localparam int S = 4;
`ifdef CFG_CRC_EN
  localparam int CRC_ON = 1;
`else
  localparam int CRC_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s_start, s_valid, s_ready, s_en, s_busy, s_done, s_err;
  logic [15:0] s_data;
  logic [3:0]  s_o;
  logic [2:0]  s_dbg;
  logic        b_start, b_valid, b_ready, b_en, b_busy, b_done, b_err;
  logic [15:0] b_data;
  logic [3:0]  b_o;
  logic [2:0]  b_dbg;

  fpga_config_loader #(.CHAINS(4), .WORD_W(16), .CHAIN_LEN(8)) u_small (
    .shift_clk(clk), .shift_rst_n(rst_n), .start(s_start), .cfg_data(s_data),
    .cfg_valid(s_valid), .cfg_ready(s_ready), .shift_en(s_en), .shift_o(s_o),
    .busy(s_busy), .done(s_done), .error(s_err), .dbg_state(s_dbg)
  );

  fpga_config_loader u_big (
    .shift_clk(clk), .shift_rst_n(rst_n), .start(b_start), .cfg_data(b_data),
    .cfg_valid(b_valid), .cfg_ready(b_ready), .shift_en(b_en), .shift_o(b_o),
    .busy(b_busy), .done(b_done), .error(b_err), .dbg_state(b_dbg)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [3:0]  exp_q[$];
  logic [15:0] words[64];
  logic [255:0] cap[4];
  logic [255:0] mdl[4];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_word(input logic [15:0] crc, input logic [15:0] w);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 16; i++) begin
      fb = c[15] ^ w[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // 0x8421 then 0xFFFF: nibbles LSB first give one-hot walking 1s, then all ones.
  task automatic push_mapping();
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    repeat (4) exp_q.push_back(4'b1111);
  endtask

  task automatic small_start();
    s_start = 1'b1;
    cyc = 0;
    tick();
    s_start = 1'b0;
    chk("start_busy", s_busy, 1);
    chk("start_ready", s_ready, 1);
    chk("start_done_clr", s_done, 0);
    chk("start_err_clr", s_err, 0);
  endtask

  task automatic small_word(input logic [15:0] w, input int stall, input bit poke_start);
    logic [3:0] e;
    repeat (stall) begin
      s_valid = 1'b0;
      tick();
      chk("stall_en", s_en, 0);
      chk("stall_ready", s_ready, 1);
    end
    s_valid = 1'b1;
    s_data  = w;
    tick();
    s_data = 16'h5A5A;
    chk("shift_ready", s_ready, 0);
    for (int k = 0; k < S; k++) begin
      if (poke_start && k == 1) s_start = 1'b1;
      tick();
      s_start = 1'b0;
      chk("shift_en", s_en, 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
      chk("shift_o", s_o, e);
    end
    s_valid = 1'b0;
  endtask

  task automatic small_finish(input int done_cyc, input logic [15:0] crc_val, input bit good);
    if (CRC_ON != 0) begin
      s_valid = 1'b1;
      s_data  = good ? crc_val : (crc_val ^ 16'h0001);
      tick();
      s_valid = 1'b0;
    end
    chk("done", s_done, good ? 1 : 0);
    chk("error", s_err, good ? 0 : 1);
    chk("done_cycle", cyc, done_cyc + CRC_ON);
    tick();
    chk("post_en", s_en, 0);
    chk("sticky_done", s_done, good ? 1 : 0);
  endtask

  initial begin
    logic [15:0] crc_s, crc_b;
    int          idx, nbits;
    bit          acc;

    s_start = 1'b1; s_valid = 1'b1; s_data = 16'h8421;
    b_start = 1'b1; b_valid = 1'b1; b_data = 16'h1234;
    crc_s = crc_word(crc_word(16'hFFFF, 16'h8421), 16'hFFFF);

    // Reset with start/valid asserted
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", s_ready, 0);
    chk("rst_en", s_en, 0);
    chk("rst_o", s_o, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);
    chk("rst_err", s_err, 0);
    chk("rst_big_busy", b_busy, 0);
    s_start = 1'b0; s_valid = 1'b0; b_start = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", s_ready, 0);
    chk("idle_busy", s_busy, 0);
    chk("idle_state", s_dbg, 0);

    // Bit mapping, back to back
    push_mapping();
    small_start();
    small_word(16'h8421, 0, 1'b0);
    small_word(16'hFFFF, 0, 1'b0);
    small_finish(11, crc_s, 1'b1);

    // Backpressure: 5 idle cycles before each word
    push_mapping();
    small_start();
    small_word(16'h8421, 5, 1'b0);
    small_word(16'hFFFF, 5, 1'b0);
    small_finish(21, crc_s, 1'b1);

    // start pulsed during SHIFT is ignored
    push_mapping();
    small_start();
    small_word(16'h8421, 0, 1'b1);
    small_word(16'hFFFF, 0, 1'b0);
    small_finish(11, crc_s, 1'b1);

    // Reset after three shifts, then a clean reload
    small_start();
    s_valid = 1'b1;
    s_data  = 16'h8421;
    tick();
    s_valid = 1'b0;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    repeat (3) begin
      tick();
      chk("pre_rst_en", s_en, 1);
      chk("pre_rst_o", s_o, exp_q.pop_front());
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_en", s_en, 0);
    chk("async_busy", s_busy, 0);
    chk("async_ready", s_ready, 0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", s_busy, 0);
    chk("post_rst_ready", s_ready, 0);
    push_mapping();
    small_start();
    small_word(16'h8421, 0, 1'b0);
    small_word(16'hFFFF, 0, 1'b0);
    small_finish(11, crc_s, 1'b1);

    if (CRC_ON != 0) begin
      // Corrupted CRC word, then a new start clears the error
      push_mapping();
      small_start();
      small_word(16'h8421, 0, 1'b0);
      small_word(16'hFFFF, 0, 1'b0);
      small_finish(11, crc_s, 1'b0);
      small_start();
    end

    // Full default-size load with a random bitstream
    crc_b = 16'hFFFF;
    for (int w = 0; w < 64; w++) begin
      words[w] = 16'($urandom_range(0, 65535));
      crc_b = crc_word(crc_b, words[w]);
    end
    for (int c = 0; c < 4; c++) begin
      cap[c] = '0;
      for (int j = 0; j < 256; j++) mdl[c][j] = words[j / 4][(j % 4) * 4 + c];
    end
    b_start = 1'b1;
    cyc = 0;
    tick();
    b_start = 1'b0;
    b_valid = 1'b1;
    b_data  = words[0];
    idx = 0;
    nbits = 0;
    while (!b_done && !b_err && cyc < 2000) begin
      acc = b_ready && b_valid;
      tick();
      if (b_en) begin
        for (int c = 0; c < 4; c++) if (nbits < 256) cap[c][nbits] = b_o[c];
        nbits++;
      end
      if (acc) begin
        idx++;
        if (idx < 64) b_data = words[idx];
        else if (idx == 64 && CRC_ON != 0) b_data = crc_b;
        else b_valid = 1'b0;
      end
    end
    b_valid = 1'b0;
    chk("big_done", b_done, 1);
    chk("big_err", b_err, 0);
    chk("big_cycles", cyc, 321 + CRC_ON);
    chk("big_bits", nbits, 256);
    for (int c = 0; c < 4; c++) chk_wide($sformatf("chain%0d", c), cap[c], mdl[c]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
